// File: rtl/fsm_arbiter_rr.sv
// fsm_arbiter_rr
// N-requester grant arbiter with a registered one-hot grant, a mandatory idle
// cycle between owners and an optional bounded hold time (MAX_HOLD) that
// forces a contended owner to release.
//
// Build option: define FSM_ARB_ROUND_ROBIN_EN for round-robin selection
// starting at ptr. Leave it undefined for fixed lowest-index priority, with
// ptr tied to 0.

module fsm_arbiter_rr #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 0,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] PARK  = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    ptr;
    logic [HC_W-1:0]    hold_cnt;

    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    scan_idx;
    logic               found;
    logic [NUM_REQ-1:0] owner_mask;
    logic               owner_req;
    logic               others_req;
    logic               hold_expired;
    logic               hold_can_inc;

    // Pick the first requester at or above ptr, wrapping around the agents
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Owner release and contention conditions used while granting
    always_comb begin
        owner_mask   = ONE_HOT_0 << owner;
        owner_req    = req[owner];
        others_req   = |(req & ~owner_mask);
        hold_expired = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD);
        hold_can_inc = (MAX_HOLD != 0) && (int'(hold_cnt) < MAX_HOLD);
    end

`ifdef FSM_ARB_ROUND_ROBIN_EN
    // Move priority to the agent just after each new owner
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == IDLE && |req) begin
            ptr <= ID_W'((int'(winner) + 1) % NUM_REQ);
        end
    end
`else
    assign ptr = '0;
`endif

    // Main grant state machine with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        owner     <= winner;
                        gnt       <= ONE_HOT_0 << winner;
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HC_W'(1);
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end else if (hold_expired && others_req) begin
                        state     <= PARK;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        preempt   <= 1'b1;
                    end else if (hold_can_inc) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                PARK: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Testbench for fsm_arbiter_rr (NUM_REQ=4, MAX_HOLD=3).
// Directed reset checks, then a scoreboard phase: the driver steps a
// cycle-level reference model and queues the expected outputs, and a
// separate monitor compares them one cycle later.

module tb_fsm_arbiter_rr;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 3;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       preempt;
    } exp_t;

    exp_t exp_q[$];
    bit   sb_on = 1'b0;

    // Reference model: who owns the bus, for how long, and how many
    // forced dead cycles remain before a new owner may be chosen
    int m_owner   = -1;
    int m_held    = 0;
    int m_cool    = 0;
    int m_ptr     = 0;
    bit m_preempt = 1'b0;

    fsm_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .preempt  (preempt)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge given the requests seen at that edge
    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        m_preempt = 1'b0;
        if (m_owner >= 0) begin
            others          = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != 4'b0) begin
                m_owner   = -1;
                m_preempt = 1'b1;
                m_cool    = 1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 4'b0) begin
`ifdef FSM_ARB_ROUND_ROBIN_EN
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
            end
            m_ptr = (m_owner + 1) % NUM_REQ;
`else
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (r[k]) m_owner = k;
            end
`endif
            m_held = 1;
        end
    endtask

    // Drive one cycle of requests, update the model and queue the expectation
    task automatic drive_cycle(input logic [3:0] r);
        exp_t e;
        req = r;
        model_step(r);
        e.valid   = (m_owner >= 0);
        e.gnt     = e.valid ? (4'b0001 << m_owner) : 4'b0000;
        e.id      = e.valid ? 2'(m_owner) : 2'b00;
        e.preempt = m_preempt;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    // Hold a request pattern; the owner drops its line once held drop_after cycles
    task automatic applyStimulus(input logic [3:0] base, input int cycles, input int drop_after);
        logic [3:0] r;
        for (int c = 0; c < cycles; c++) begin
            r = base;
            if (drop_after > 0 && m_owner >= 0 && m_held >= drop_after) r[m_owner] = 1'b0;
            drive_cycle(r);
        end
    endtask

    // Random sticky request patterns with random owner releases
    task automatic apply_random(input int cycles);
        logic [3:0] base;
        logic [3:0] r;
        int         left;
        base = 4'b0;
        left = 0;
        for (int c = 0; c < cycles; c++) begin
            if (left == 0) begin
                base = 4'($urandom_range(0, 15));
                left = $urandom_range(1, 6);
            end
            left--;
            r = base;
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) r[m_owner] = 1'b0;
            drive_cycle(r);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("gnt", 32'(gnt), 32'(e.gnt));
                checkOutput("gnt_valid", 32'(gnt_valid), 32'(e.valid));
                checkOutput("preempt", 32'(preempt), 32'(e.preempt));
                if (e.valid) checkOutput("gnt_id", 32'(gnt_id), 32'(e.id));
            end
        end
    end

    // Directed reset checks followed by the scoreboard phases
    initial begin
        req   = 4'b0;
        reset = 1'b0;
        #1;
        checkOutput("reset gnt", 32'(gnt), 32'h0);
        checkOutput("reset gnt_valid", 32'(gnt_valid), 32'h0);
        checkOutput("reset preempt", 32'(preempt), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        @(negedge clock);
        req = 4'b0010;
        @(posedge clock);
        #1;
        checkOutput("first grant", 32'(gnt), 32'h2);
        checkOutput("first grant id", 32'(gnt_id), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset gnt", 32'(gnt), 32'h0);
        checkOutput("async reset gnt_valid", 32'(gnt_valid), 32'h0);
        checkOutput("async reset preempt", 32'(preempt), 32'h0);

        @(negedge clock);
        reset = 1'b1;
        req   = 4'b0110;
        @(posedge clock);
        #1;
        checkOutput("grant after reset", 32'(gnt), 32'h2);
        checkOutput("grant after reset id", 32'(gnt_id), 32'h1);

        @(negedge clock);
        req   = 4'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sb_on = 1'b1;

        applyStimulus(4'b1111, 24, 2);
        applyStimulus(4'b0000, 2, 0);
        applyStimulus(4'b0101, 30, 0);
        applyStimulus(4'b0000, 2, 0);
        applyStimulus(4'b0010, 20, 0);
        applyStimulus(4'b0000, 2, 0);
        applyStimulus(4'b0100, 2, 0);
        applyStimulus(4'b0000, 1, 0);
        applyStimulus(4'b0011, 8, 2);
        applyStimulus(4'b0000, 2, 0);
        applyStimulus(4'b1010, 20, 2);
        applyStimulus(4'b1000, 4, 0);
        applyStimulus(4'b0000, 2, 0);
        apply_random(400);

        @(posedge clock);
        #2;
        checkOutput("queue drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_arbiter_rr.md
# fsm_arbiter_rr

Parametrised N-requester grant arbiter, the generalised successor to the team's fixed 4-agent grant FSM. It accepts `NUM_REQ` active-high request lines and issues one registered, one-hot grant at a time. Fairness is round-robin, with an optional bounded hold time that forces a contended owner to release. It sits between request-generating agents and a shared resource (bus, memory port), in the same position as the existing grant FSMs.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 0: maximum grant cycles before forced release under contention; 0 = unlimited; legal range 0..255.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `gnt_id`; derived, not overridden.
- `clock`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset (asserted when 0).
- `req`, in, `NUM_REQ`: active-high request, one bit per agent; level-sensitive.
- `gnt`, out, `NUM_REQ`: active-high grant, registered, one-hot or zero.
- `gnt_id`, out, `ID_W`: index of current owner; valid only when `gnt_valid`=1.
- `gnt_valid`, out, 1: registered; equals OR of `gnt`.
- `preempt`, out, 1: registered one-cycle pulse when a grant is revoked by hold timeout.

## Operation
- States: IDLE, GRANT, PARK. Reset state is IDLE.
- Registers: `owner`, `ptr` (next-highest-priority index), `hold_cnt` (width `$clog2(MAX_HOLD+1)`, minimum 1).
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0, `ptr`=0, `hold_cnt`=0, `owner`=0.
- IDLE:
  - If `req`==0, stay.
  - Otherwise select winner W: first set bit scanning from `ptr` upward, wrapping modulo `NUM_REQ`.
  - Go to GRANT with `owner`=W, `gnt`=one-hot(W), `gnt_id`=W, `hold_cnt`=1, `ptr`=(W+1) mod `NUM_REQ`.
- GRANT:
  - If `req[owner]`=0: go to IDLE and clear `gnt`. Release takes priority over timeout.
  - Else if `MAX_HOLD`!=0, `hold_cnt`>=`MAX_HOLD`, and any other `req` bit is set: go to PARK, clear `gnt`, pulse `preempt`.
  - Else stay; `hold_cnt` increments, saturating at `MAX_HOLD`. With `MAX_HOLD`=0 the counter does not increment.
- PARK: one dead cycle with no grant; always go to IDLE. This guarantees a one-cycle bus turnaround after a forced release. `ptr` has already advanced past the preempted owner.
- No grant is issued in the same edge that another is removed; there is always at least one cycle with `gnt`=0 between owners.
- Requests arriving or dropping in PARK are ignored until IDLE.
- Unreachable state encoding: go to IDLE with `gnt` cleared.

## Timing
- Grant latency: request seen high at edge k while in IDLE gives `gnt` high after edge k. The minimum request-to-grant latency is 1 cycle.
- Release latency: `req[owner]` low at edge k gives `gnt` low after edge k, then IDLE for one cycle. The earliest next grant is after edge k+1.
- Forced release: `gnt` is held exactly `MAX_HOLD` cycles, then `gnt` is low and `preempt` is high for one cycle (PARK). The next owner's `gnt` rises 2 cycles after the preempting edge.
- Reset mid-GRANT: all outputs clear asynchronously on reset assertion, independent of `clock`. The first grant after deassertion uses `ptr`=0.
- The `#1` assignment delays used in legacy grant FSMs are not used; outputs change at the clock edge only.

## Configuration
- `FSM_ARB_ROUND_ROBIN_EN` defined: round-robin selection from `ptr` as above, with `ptr` updated on each grant.
- `FSM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the lowest set index of `req` always wins.
  - `ptr` is removed and tied to 0.
  - Hold-timeout preemption still operates, but the preempted owner may win again from IDLE if it has the lowest index. This is legacy-compatible behaviour.

## Test plan
- Reset: drive `reset`=0 mid-grant with `req`=4'b0010 -> `gnt`=0, `gnt_valid`=0, `preempt`=0 immediately; after release, the first grant goes to agent 1 one cycle later.
- Round-robin: `NUM_REQ`=4, `req`=4'b1111 held, each owner dropping its request after 2 cycles -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Wrap-around: `ptr`=3 after granting agent 2, `req`=4'b0011 -> agent 0 granted, then `ptr`=1.
- Preemption: `MAX_HOLD`=3, agent 0 holds `req` while agent 2 requests -> `gnt[0]` high for exactly 3 cycles, `preempt` pulses 1 cycle, then `gnt[2]` is high.
- No contention: `MAX_HOLD`=3, only agent 1 requesting for 20 cycles -> `gnt[1]` high all 20 cycles and `preempt` never asserts.
- Fixed priority (macro undefined): `req`=4'b1010 held with repeated releases -> agent 1 always wins; agent 3 is granted only when `req[1]`=0.
